// File: rtl/uart_link.sv
// Full-duplex 8N1 UART: shared 16x oversample baud generator, LSB-first transmitter
// and a mid-bit sampling receiver behind a 2-flop synchronizer.
module uart_link #(
    parameter int DIV_W = 16,
    parameter int OVS   = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             Rx,
    input  logic [7:0]       data_in,
    output logic             baud_tick,
    output logic [7:0]       data_out,
    output logic             Tx
);

    localparam int OW = $clog2(OVS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t tx_state, tx_next;
    state_t rx_state, rx_next;

    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] div_q;
    logic             busy;
    logic             run;
    logic             terminal;
    logic             tick;

    logic [OW-1:0]    tx_ticks;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_bit_end;
    logic             tx_load;

    logic [2:0]       rx_sync;
    logic             rx_s;
    logic             rx_fall;
    logic [OW-1:0]    rx_ticks;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_mid_start;
    logic             rx_bit_end;
    logic             rx_shift_en;
    logic             rx_capture;

    // The counter only advances once a state machine is busy, so a frame that starts
    // from an idle link gets a full-length first bit.
    assign busy      = (tx_state != IDLE) || (rx_state != IDLE);
    assign run       = en || busy;
    assign terminal  = (div_q <= DIV_W'(1)) || (baud_cnt == div_q - DIV_W'(1));
    assign tick      = run && terminal && !arst_n;
    assign baud_tick = tick;

    always_ff @(posedge clk) begin
        if (arst_n) begin
            baud_cnt <= '0;
            div_q    <= baud_div;
        end else if (!busy || terminal) begin
            baud_cnt <= '0;
            div_q    <= baud_div;
        end else begin
            baud_cnt <= baud_cnt + DIV_W'(1);
        end
    end

    assign tx_bit_end = tick && (tx_ticks == OW'(OVS - 1));
    assign tx_load    = en && ((tx_state == IDLE) || ((tx_state == STOP) && tx_bit_end));

    always_ff @(posedge clk) begin
        if (arst_n) tx_state <= IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:    if (en) tx_next = START;
            START:   if (tx_bit_end) tx_next = DATA;
            DATA:    if (tx_bit_end && (tx_bit == 3'd7)) tx_next = STOP;
            STOP:    if (tx_bit_end) tx_next = en ? START : IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_comb begin
        Tx = 1'b1;
        case (tx_state)
            START:   Tx = 1'b0;
            DATA:    Tx = tx_shift[0];
            default: Tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst_n) begin
            tx_ticks <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (tx_load) begin
            tx_ticks <= '0;
            tx_bit   <= '0;
            tx_shift <= data_in;
        end else if (tx_state == IDLE) begin
            tx_ticks <= '0;
            tx_bit   <= '0;
        end else if (tick) begin
            tx_ticks <= tx_ticks + OW'(1);
            if ((tx_state == DATA) && tx_bit_end) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

    // rx_sync[1] is the synchronized line; rx_sync[2] is its previous value, used to
    // arm only on a genuine falling edge (not on a line still low after a framing error).
    always_ff @(posedge clk) begin
        if (arst_n) rx_sync <= 3'b111;
        else        rx_sync <= {rx_sync[1:0], Rx};
    end

    assign rx_s         = rx_sync[1];
    assign rx_fall      = rx_sync[2] && !rx_sync[1];
    assign rx_mid_start = tick && (rx_ticks == OW'(OVS / 2 - 1));
    assign rx_bit_end   = tick && (rx_ticks == OW'(OVS - 1));

    always_ff @(posedge clk) begin
        if (arst_n) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:    if (rx_fall) rx_next = START;
            START:   if (rx_mid_start) rx_next = rx_s ? IDLE : DATA;
            DATA:    if (rx_bit_end && (rx_bit == 3'd7)) rx_next = STOP;
            STOP:    if (rx_bit_end) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_comb begin
        rx_shift_en = (rx_state == DATA) && rx_bit_end;
        rx_capture  = (rx_state == STOP) && rx_bit_end && rx_s;
    end

    always_ff @(posedge clk) begin
        if (arst_n) begin
            rx_ticks <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            data_out <= '0;
        end else begin
            if (rx_state == IDLE) begin
                rx_ticks <= '0;
                rx_bit   <= '0;
            end else if ((rx_state == START) && rx_mid_start) begin
                rx_ticks <= '0;
            end else if (tick) begin
                rx_ticks <= rx_ticks + OW'(1);
            end
            if (rx_shift_en) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            if (rx_capture) data_out <= rx_shift;
        end
    end

endmodule

// File: tb/tb_uart_link.sv
// Scoreboard bench for uart_link: stimulus queues expected TX frames and RX bytes,
// independent monitors decode the Tx line and watch data_out.
module tb_uart_link;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        en;
    logic [15:0] baud_div;
    logic        rx_line;
    logic [7:0]  data_in;
    logic        baud_tick;
    logic [7:0]  data_out;
    logic        tx_line;
    logic        loopback;
    logic        rx_drv;

    typedef struct {
        logic [7:0] data;
        bit         contig;
    } tx_item_t;

    tx_item_t   tx_exp[$];
    logic [7:0] rx_exp[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bit_clks = 16;
    int n;

    assign rx_line = loopback ? tx_line : rx_drv;

    uart_link #(.DIV_W(16), .OVS(16)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .en        (en),
        .baud_div  (baud_div),
        .Rx        (rx_line),
        .data_in   (data_in),
        .baud_tick (baud_tick),
        .data_out  (data_out),
        .Tx        (tx_line)
    );

    always #25 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic setDiv(input logic [15:0] d);
        baud_div = d;
        bit_clks = 16 * ((d < 16'd2) ? 1 : int'(d));
    endtask

    task automatic applyStimulus(input logic [7:0] d, input int hold);
        @(posedge clk);
        #1;
        data_in = d;
        en = 1'b1;
        waitCycles(hold);
        en = 1'b0;
    endtask

    task automatic sendRxFrame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            waitCycles(bit_clks);
        end
        rx_drv = 1'b1;
    endtask

    task automatic countTicks(input int window, output int count);
        count = 0;
        repeat (window) begin
            @(negedge clk);
            if (baud_tick === 1'b1) count++;
        end
    endtask

    // Tx monitor: decode each frame, checking every bit is flat for its whole period.
    initial begin
        logic       prev_tx;
        logic [9:0] first, mid, last;
        int         t0, last_t0, b, k, r, bad;
        bit         aborted;
        tx_item_t   item;
        prev_tx = 1'b1;
        last_t0 = 0;
        forever begin
            @(negedge clk);
            if (arst_n === 1'b1 || !(prev_tx === 1'b1 && tx_line === 1'b0)) begin
                prev_tx = (arst_n === 1'b1) ? 1'b1 : tx_line;
                continue;
            end
            t0 = cyc;
            b = bit_clks;
            aborted = 1'b0;
            first = '0;
            mid = '0;
            last = '0;
            for (int i = 0; i < 10 * b; i++) begin
                if (i > 0) @(negedge clk);
                if (arst_n === 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                k = i / b;
                r = i % b;
                if (r == 0)     first[k] = tx_line;
                if (r == b / 2) mid[k]   = tx_line;
                if (r == b - 1) last[k]  = tx_line;
            end
            if (aborted) begin
                prev_tx = 1'b1;
                continue;
            end
            prev_tx = tx_line;
            bad = 0;
            for (int j = 0; j < 10; j++)
                if (first[j] !== mid[j] || last[j] !== mid[j]) bad++;
            if (tx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL tx_unexpected: got frame %0h, expected no frame", mid[8:1]);
            end else begin
                item = tx_exp.pop_front();
                checkOutput("tx_byte", mid[8:1], item.data);
                checkOutput("tx_framing", {mid[9], mid[0]}, 2'b10);
                checkOutput("tx_bit_timing", bad, 0);
                if (item.contig) checkOutput("tx_gap", t0 - last_t0, 10 * b);
            end
            last_t0 = t0;
        end
    end

    // data_out monitor: every change outside reset must match the next queued byte.
    initial begin
        logic [7:0] prev;
        prev = 8'h00;
        forever begin
            @(negedge clk);
            if (arst_n === 1'b1) begin
                prev = data_out;
            end else if (data_out !== prev) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rx_unexpected: got %0h, expected no update", data_out);
                end else begin
                    checkOutput("rx_byte", data_out, rx_exp.pop_front());
                end
                prev = data_out;
            end
        end
    end

    initial begin
        arst_n = 1'b1;
        en = 1'b0;
        data_in = 8'h00;
        rx_drv = 1'b1;
        loopback = 1'b0;
        setDiv(16'd130);

        // Reset, then idle with en low
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_tx", tx_line, 1'b1);
        checkOutput("reset_data_out", data_out, 8'h00);
        countTicks(200, n);
        checkOutput("idle_ticks", n, 0);

        // Single frame at baud_div=130 (2080 clk per bit)
        tx_exp.push_back('{data: 8'hB4, contig: 1'b0});
        applyStimulus(8'hB4, 50);
        waitCycles(bit_clks);
        countTicks(1300, n);
        checkOutput("ticks_per_1300_clk", n, 10);
        waitCycles(9 * bit_clks);

        // Back-to-back frames, data_in changed mid-frame
        setDiv(16'd4);
        tx_exp.push_back('{data: 8'hB4, contig: 1'b0});
        tx_exp.push_back('{data: 8'hA5, contig: 1'b1});
        @(posedge clk);
        #1;
        data_in = 8'hB4;
        en = 1'b1;
        waitCycles(3 * bit_clks);
        data_in = 8'hA5;
        waitCycles(10 * bit_clks);
        en = 1'b0;
        waitCycles(10 * bit_clks);

        // baud_div=1: tick every clk
        setDiv(16'd1);
        tx_exp.push_back('{data: 8'h5A, contig: 1'b0});
        applyStimulus(8'h5A, 1);
        waitCycles(20);
        countTicks(40, n);
        checkOutput("div1_ticks", n, 40);
        waitCycles(10 * bit_clks);

        // Loopback
        setDiv(16'd4);
        loopback = 1'b1;
        tx_exp.push_back('{data: 8'hB4, contig: 1'b0});
        rx_exp.push_back(8'hB4);
        applyStimulus(8'hB4, 1);
        waitCycles(11 * bit_clks);
        checkOutput("loop_data_out_b4", data_out, 8'hB4);
        tx_exp.push_back('{data: 8'hA5, contig: 1'b0});
        rx_exp.push_back(8'hA5);
        applyStimulus(8'hA5, 1);
        waitCycles(11 * bit_clks);
        checkOutput("loop_data_out_a5", data_out, 8'hA5);

        // Glitch and framing error leave data_out alone
        loopback = 1'b0;
        rx_drv = 1'b0;
        waitCycles(20);
        rx_drv = 1'b1;
        waitCycles(2 * bit_clks);
        checkOutput("glitch_data_out", data_out, 8'hA5);
        sendRxFrame(8'h77, 1'b0);
        waitCycles(2 * bit_clks);
        checkOutput("framing_err_data_out", data_out, 8'hA5);
        rx_exp.push_back(8'h3C);
        sendRxFrame(8'h3C, 1'b1);
        waitCycles(2 * bit_clks);
        checkOutput("after_err_data_out", data_out, 8'h3C);

        // Reset in the middle of a looped-back frame
        loopback = 1'b1;
        applyStimulus(8'hC3, 1);
        waitCycles(5 * bit_clks);
        arst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_tx", tx_line, 1'b1);
        checkOutput("midreset_data_out", data_out, 8'h00);
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        waitCycles(4);
        tx_exp.push_back('{data: 8'h69, contig: 1'b0});
        rx_exp.push_back(8'h69);
        applyStimulus(8'h69, 1);
        waitCycles(11 * bit_clks);
        checkOutput("post_reset_data_out", data_out, 8'h69);

        checkOutput("tx_queue_empty", tx_exp.size(), 0);
        checkOutput("rx_queue_empty", rx_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_link.md
Name: uart_link

Overview:
- Full-duplex 8N1 UART core: programmable baud-tick generator, transmitter and receiver in one block.
- Sits between a byte-parallel host interface (data_in/data_out) and the serial pins (Tx/Rx).
- Generator produces a 16x-oversample tick. With a 20 MHz clk and baud_div=130 the line rate is about 9615 baud.

Parameters:
- DIV_W, 16, width of baud_div.
- OVS, 16, oversample ticks per bit (fixed value; not required to be changeable).

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- arst_n  in  1  reset; synchronous, active-high. The name is kept from the codebase; logic 1 resets.
- en  in  1  enable; while high, the transmitter sends data_in frames back-to-back.
- baud_div  in  DIV_W  clocks per oversample tick.
- Rx  in  1  serial receive line, asynchronous, idle high.
- data_in  in  8  byte to transmit; sampled at each frame start.
- baud_tick  out  1  one-clk pulse, once per oversample period.
- data_out  out  8  last correctly framed received byte.
- Tx  out  1  serial transmit line, idle high.

Behaviour:
Reset (arst_n=1 at a clk edge):
- Tx=1, baud_tick=0, data_out=8'h00.
- Baud counter=0; TX and RX FSMs go to IDLE; synchronizer flops=1.
- Reset mid-frame aborts the frame immediately. No partial byte reaches data_out.

Baud generator:
- Runs when en=1, or TX is not IDLE, or RX is not IDLE.
- Otherwise the counter is held at 0 and baud_tick=0.
- Counter counts 0..baud_div-1. baud_tick=1 for exactly the one clk in which the counter equals baud_div-1, then the counter wraps to 0.
- baud_div of 0 or 1: baud_tick is high every clk.
- A change to baud_div takes effect at the next wrap.

Transmitter FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: Tx=1. On a clk edge with en=1:
  - latch data_in into an 8-bit shift register;
  - clear the tick sub-counter;
  - go to START; Tx drives 0 from the next clk.
- Every bit (START, each DATA bit, STOP) lasts exactly 16 baud_ticks.
- DATA sends bit0 first (LSB first): 8 bits, one shift per 16 ticks.
- STOP: Tx=1 for 16 ticks.
- After STOP, if en=1 the next frame starts immediately (no idle gap) with a fresh sample of data_in; otherwise go to IDLE.
- en dropping mid-frame does not truncate the frame; it completes.
- data_in changes mid-frame do not affect the frame in flight.

Receiver:
- Rx passes through a 2-flop synchronizer before any use.
- IDLE: wait for synchronized Rx=0, then START with the tick sub-counter cleared.
- START: after 8 ticks (mid start bit) resample.
  - If 1: glitch; return to IDLE.
  - If 0: clear the sub-counter and go to DATA.
- DATA: sample at every 16th tick (mid-bit) and shift into bit7, so the first received bit ends in bit0. After 8 samples go to STOP.
- STOP: sample at the 16th tick.
  - If 1: data_out <= assembled byte on that clk.
  - If 0 (framing error): data_out unchanged.
  - Either way return to IDLE and re-arm on the next falling edge.
- Latency: data_out updates about 9.5 bit periods after the start-bit falling edge, plus 2 clk of synchronizer delay.
- The receiver is independent of TX; both may be active simultaneously.

Timing at baud_div=130, clk 50 ns:
- tick period 6.5 us; bit period 104 us; frame 1.04 ms.

Test Plan:
1. Reset then idle:
   - assert arst_n=1 for 2 clk, then release with en=0, Rx=1;
   - expect Tx=1, data_out=00, no baud_tick pulses.
2. Single TX frame:
   - baud_div=130, data_in=8'hB4, pulse en high for less than one frame;
   - expect Tx to show start(0), bits 0,0,1,0,1,1,0,1, stop(1), each 2080 clk, then idle high.
3. Back-to-back TX:
   - en held high 2 ms with data_in=B4, then data_in=A5 while a frame is in flight;
   - expect the in-flight frame unchanged, A5 sent in the next frame, and no gap between stop and start.
4. Loopback RX:
   - tie Tx to Rx externally; send B4, then A5;
   - expect data_out=B4 at about 1.04 ms after frame start, then A5.
5. RX robustness:
   - drive a 1 us low glitch on Rx, expect data_out unchanged;
   - drive a frame with stop bit=0, expect data_out unchanged and the receiver accepting the next valid frame (8'h3C).
6. Reset mid-frame:
   - assert arst_n during a TX and an RX frame;
   - expect Tx=1 next clk, data_out=00, and clean operation for the following frame.
